// File: rtl/cson_isa_pkg.sv
// Shared ISA definitions for the decode stage: field layout, class and
// condition encodings, decode FSM states and the flag scoreboard depth.
package cson_isa_pkg;

   localparam int FLAG_DEPTH_DEF = 3;

   localparam int COND_LSB = 28;
   localparam int CLS_LSB  = 26;
   localparam int OP_LSB   = 22;
   localparam int S_BIT    = 21;
   localparam int RD_LSB   = 16;
   localparam int RS1_LSB  = 11;
   localparam int RS2_LSB  = 6;

   typedef enum logic [1:0] {
      CLS_REG = 2'b00,
      CLS_IMM = 2'b01,
      CLS_MEM = 2'b10,
      CLS_BR  = 2'b11
   } cls_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

   typedef enum logic [1:0] {
      ST_EMPTY      = 2'd0,
      ST_WAIT_FLAGS = 2'd1,
      ST_OUT        = 2'd2
   } state_t;

   // Branch offsets are word offsets, hence the shift by two.
   function automatic logic [31:0] decode_imm(input logic [31:0] ir);
      logic [31:0] imm;
      case (ir[CLS_LSB +: 2])
         CLS_IMM: imm = {21'd0, ir[10:0]};
         CLS_MEM: imm = {{21{ir[10]}}, ir[10:0]};
         CLS_BR:  imm = {{4{ir[25]}}, ir[25:0], 2'b00};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Resolves an ARM-style condition code against the {N,Z,C,V} flags.
module cond_eval
   import cson_isa_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] NZCV,
   output logic       pass
);

   logic n, z, c, v;

   assign {n, z, c, v} = NZCV;

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/decode_instruction.sv
// Decode stage: splits the IR into fields, resolves the condition against
// NZCV once pending flag writers drain, and hands one result to execute.
module decode_instruction
   import cson_isa_pkg::*;
#(
   parameter int FLAG_DEPTH = FLAG_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IR,
   input  logic        W_IR_valid,
   output logic        ir_ready,
   input  logic [3:0]  NZCV,
   input  logic        flags_wr,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [1:0]  dec_cls,
   output logic [3:0]  dec_op,
   output logic        dec_s,
   output logic [4:0]  dec_rd,
   output logic [4:0]  dec_rs1,
   output logic [4:0]  dec_rs2,
   output logic [31:0] dec_imm,
   output logic        dec_exec,
   output logic [1:0]  fsm_state,
   output logic [1:0]  pend_cnt
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid is held, with its payload stable, until then.

   localparam logic [1:0] DEPTH_CNT = 2'(FLAG_DEPTH);

   state_t      state_q, state_d;
   logic [1:0]  pend_q, pend_d;
   logic [3:0]  cond_q, cond_d;
   logic        valid_q, valid_d;
   logic [1:0]  cls_q, cls_d;
   logic [3:0]  op_q, op_d;
   logic        s_q, s_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [31:0] imm_q, imm_d;
   logic        exec_q, exec_d;

   logic        handoff, capture, pend_inc, pend_dec, pass;
   logic [1:0]  ir_cls;
   logic [3:0]  ir_cond, cond_sel;

   assign ir_cls   = IR[CLS_LSB +: 2];
   assign ir_cond  = IR[COND_LSB +: 4];
   assign ir_ready = rst && ((state_q == ST_EMPTY) ||
                             ((state_q == ST_OUT) && valid_q && dec_ready));
   assign handoff  = valid_q && dec_ready;
   assign capture  = W_IR_valid && ir_ready;
   assign pend_inc = handoff && s_q && exec_q;
   assign pend_dec = flags_wr && (pend_q != 2'd0);
   assign pend_d   = pend_q + {1'b0, pend_inc} - {1'b0, pend_dec};

   // Only one condition is ever resolved per cycle: the held one while
   // waiting for flags, otherwise the one arriving on IR.
   assign cond_sel = (state_q == ST_WAIT_FLAGS) ? cond_q : ir_cond;

   cond_eval u_cond_eval (
      .cond (cond_sel),
      .NZCV (NZCV),
      .pass (pass)
   );

   always_comb begin
      state_d = state_q;
      cond_d  = cond_q;
      cls_d   = cls_q;
      op_d    = op_q;
      s_d     = s_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      exec_d  = exec_q;

      case (state_q)
         ST_EMPTY: ;
         ST_WAIT_FLAGS: begin
            if (pend_q == 2'd0) begin
               exec_d  = pass;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (handoff) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase

      if (capture) begin
         cls_d  = ir_cls;
         op_d   = (ir_cls != CLS_BR) ? IR[OP_LSB +: 4] : 4'd0;
         s_d    = (ir_cls == CLS_REG || ir_cls == CLS_IMM) ? IR[S_BIT] : 1'b0;
         rd_d   = (ir_cls != CLS_BR) ? IR[RD_LSB +: 5] : 5'd0;
         rs1_d  = (ir_cls != CLS_BR) ? IR[RS1_LSB +: 5] : 5'd0;
         rs2_d  = (ir_cls == CLS_REG) ? IR[RS2_LSB +: 5] : 5'd0;
         imm_d  = decode_imm(IR);
         cond_d = ir_cond;
         // The count used here includes this cycle's handoff and flags_wr.
         if (ir_cond == COND_AL || ir_cond == COND_NV || pend_d == 2'd0) begin
            state_d = ST_OUT;
            exec_d  = pass;
         end else begin
            state_d = ST_WAIT_FLAGS;
            exec_d  = 1'b0;
         end
      end

      // A flag-setter is held back when the scoreboard has no free slot.
      valid_d = (state_d == ST_OUT) && !(s_d && exec_d && (pend_d == DEPTH_CNT));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         pend_q  <= 2'd0;
         cond_q  <= 4'd0;
         valid_q <= 1'b0;
         cls_q   <= 2'd0;
         op_q    <= 4'd0;
         s_q     <= 1'b0;
         rd_q    <= 5'd0;
         rs1_q   <= 5'd0;
         rs2_q   <= 5'd0;
         imm_q   <= 32'd0;
         exec_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cond_q  <= cond_d;
         valid_q <= valid_d;
         cls_q   <= cls_d;
         op_q    <= op_d;
         s_q     <= s_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         imm_q   <= imm_d;
         exec_q  <= exec_d;
      end
   end

   assign dec_valid = valid_q;
   assign dec_cls   = cls_q;
   assign dec_op    = op_q;
   assign dec_s     = s_q;
   assign dec_rd    = rd_q;
   assign dec_rs1   = rs1_q;
   assign dec_rs2   = rs2_q;
   assign dec_imm   = imm_q;
   assign dec_exec  = exec_q;
   assign fsm_state = state_q;
   assign pend_cnt  = pend_q;

endmodule

// File: tb/tb_decode_instruction.sv
// Directed bench for decode_instruction: field decode, conditions, flag
// scoreboard wait and depth hold, back-pressure and reset mid-operation.
module tb_decode_instruction;

   logic        clk;
   logic        rst;
   logic [31:0] IR;
   logic        W_IR_valid;
   logic        ir_ready;
   logic [3:0]  NZCV;
   logic        flags_wr;
   logic        dec_valid;
   logic        dec_ready;
   logic [1:0]  dec_cls;
   logic [3:0]  dec_op;
   logic        dec_s;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [31:0] dec_imm;
   logic        dec_exec;
   logic [1:0]  fsm_state;
   logic [1:0]  pend_cnt;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] IR_ADDI = 32'hE4030805;
   localparam logic [31:0] IR_BEQ  = 32'h0FFFFFFE;

   decode_instruction dut (
      .clk        (clk),
      .rst        (rst),
      .IR         (IR),
      .W_IR_valid (W_IR_valid),
      .ir_ready   (ir_ready),
      .NZCV       (NZCV),
      .flags_wr   (flags_wr),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_cls    (dec_cls),
      .dec_op     (dec_op),
      .dec_s      (dec_s),
      .dec_rd     (dec_rd),
      .dec_rs1    (dec_rs1),
      .dec_rs2    (dec_rs2),
      .dec_imm    (dec_imm),
      .dec_exec   (dec_exec),
      .fsm_state  (fsm_state),
      .pend_cnt   (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0] cond;
      logic [3:0] flags;
      logic       exp;
   } cond_vec_t;

   cond_vec_t cvec [10] = '{
      '{4'h8, 4'b0010, 1'b1},
      '{4'h9, 4'b0010, 1'b0},
      '{4'hA, 4'b1001, 1'b1},
      '{4'hB, 4'b1001, 1'b0},
      '{4'hC, 4'b0000, 1'b1},
      '{4'hD, 4'b0100, 1'b1},
      '{4'hF, 4'b1111, 1'b0},
      '{4'h4, 4'b1000, 1'b1},
      '{4'h7, 4'b0001, 1'b0},
      '{4'h1, 4'b0100, 1'b0}
   };

   initial begin
      logic [31:0] ir_a, ir_b, ir_c, ir_d, ir_s;
      ir_s = {4'hE, 2'b00, 4'h2, 1'b1, 5'd5, 5'd6, 5'd7, 6'd0};
      ir_a = {4'hE, 2'b00, 4'h9, 1'b0, 5'd1, 5'd2, 5'd3, 6'd0};
      ir_b = {4'hE, 2'b01, 4'h3, 1'b0, 5'd4, 5'd8, 11'h7FF};
      ir_c = {4'hE, 2'b00, 4'h1, 1'b1, 5'd2, 5'd2, 5'd2, 6'd0};
      ir_d = {4'hE, 2'b10, 4'h4, 1'b1, 5'd9, 5'd10, 11'h400};

      rst = 1'b0; IR = 32'd0; W_IR_valid = 1'b0; NZCV = 4'd0;
      flags_wr = 1'b0; dec_ready = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_ir_ready", 32'(ir_ready), 32'd0);
      check("rst_valid", 32'(dec_valid), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
      check("rst_pend", 32'(pend_cnt), 32'd0);
      check("rst_imm", dec_imm, 32'd0);
      rst = 1'b1;

      // ALU-immediate capture
      IR = IR_ADDI; W_IR_valid = 1'b1; dec_ready = 1'b1;
      #1 check("addi_ir_ready", 32'(ir_ready), 32'd1);
      tick(); W_IR_valid = 1'b0;
      check("addi_valid", 32'(dec_valid), 32'd1);
      check("addi_cls", 32'(dec_cls), 32'd1);
      check("addi_rd", 32'(dec_rd), 32'd3);
      check("addi_rs1", 32'(dec_rs1), 32'd1);
      check("addi_rs2", 32'(dec_rs2), 32'd0);
      check("addi_imm", dec_imm, 32'd5);
      check("addi_exec", 32'(dec_exec), 32'd1);
      tick();
      check("addi_empty", 32'(fsm_state), 32'd0);
      check("addi_valid_drop", 32'(dec_valid), 32'd0);

      // Branch, condition passes then fails
      NZCV = 4'b0100; IR = IR_BEQ; W_IR_valid = 1'b1;
      tick(); W_IR_valid = 1'b0;
      check("beq_cls", 32'(dec_cls), 32'd3);
      check("beq_imm", dec_imm, 32'hFFFFFFF8);
      check("beq_op", 32'(dec_op), 32'd0);
      check("beq_rd", 32'(dec_rd), 32'd0);
      check("beq_exec", 32'(dec_exec), 32'd1);
      tick();
      NZCV = 4'b0000; W_IR_valid = 1'b1;
      tick(); W_IR_valid = 1'b0;
      check("beq_fail_valid", 32'(dec_valid), 32'd1);
      check("beq_fail_exec", 32'(dec_exec), 32'd0);
      tick();
      check("beq_fail_handed", 32'(dec_valid), 32'd0);

      // Scoreboard wait: S=1 handoff coincides with BEQ capture
      IR = ir_s; W_IR_valid = 1'b1;
      tick();
      check("s_s", 32'(dec_s), 32'd1);
      check("s_op", 32'(dec_op), 32'd2);
      check("s_rs2", 32'(dec_rs2), 32'd7);
      IR = IR_BEQ; NZCV = 4'b0000;
      #1 check("s_ir_ready", 32'(ir_ready), 32'd1);
      tick(); W_IR_valid = 1'b0;
      check("wait_state", 32'(fsm_state), 32'd1);
      check("wait_valid", 32'(dec_valid), 32'd0);
      check("wait_pend", 32'(pend_cnt), 32'd1);
      check("wait_ir_ready", 32'(ir_ready), 32'd0);
      tick();
      check("wait_hold", 32'(dec_valid), 32'd0);
      flags_wr = 1'b1; NZCV = 4'b0100;
      tick(); flags_wr = 1'b0;
      check("wait_pend0", 32'(pend_cnt), 32'd0);
      check("wait_valid_still0", 32'(dec_valid), 32'd0);
      tick();
      check("wait_release_valid", 32'(dec_valid), 32'd1);
      check("wait_release_exec", 32'(dec_exec), 32'd1);
      check("wait_release_imm", dec_imm, 32'hFFFFFFF8);
      tick();
      check("wait_done_state", 32'(fsm_state), 32'd0);

      // Back-pressure
      dec_ready = 1'b0; IR = ir_a; W_IR_valid = 1'b1;
      tick();
      IR = ir_b;
      for (int i = 0; i < 3; i++) begin
         check("bp_ir_ready", 32'(ir_ready), 32'd0);
         tick();
         check("bp_valid", 32'(dec_valid), 32'd1);
         check("bp_rd", 32'(dec_rd), 32'd1);
         check("bp_rs2", 32'(dec_rs2), 32'd3);
         check("bp_op", 32'(dec_op), 32'd9);
      end
      dec_ready = 1'b1;
      #1 check("bp_release_ready", 32'(ir_ready), 32'd1);
      tick();
      check("bp_next_valid", 32'(dec_valid), 32'd1);
      check("bp_next_cls", 32'(dec_cls), 32'd1);
      check("bp_next_rd", 32'(dec_rd), 32'd4);
      check("bp_next_rs1", 32'(dec_rs1), 32'd8);
      check("bp_next_rs2", 32'(dec_rs2), 32'd0);
      check("bp_next_imm", dec_imm, 32'h000007FF);

      // Load/store with negative offset, then reset while holding it
      IR = ir_c;
      tick();
      check("c_s", 32'(dec_s), 32'd1);
      IR = ir_d;
      tick(); W_IR_valid = 1'b0; dec_ready = 1'b0;
      check("d_pend", 32'(pend_cnt), 32'd1);
      check("d_cls", 32'(dec_cls), 32'd2);
      check("d_s", 32'(dec_s), 32'd0);
      check("d_op", 32'(dec_op), 32'd4);
      check("d_rs2", 32'(dec_rs2), 32'd0);
      check("d_imm", dec_imm, 32'hFFFFFC00);
      rst = 1'b0;
      #1 check("rst_mid_ir_ready", 32'(ir_ready), 32'd0);
      tick();
      check("rst_mid_valid", 32'(dec_valid), 32'd0);
      check("rst_mid_pend", 32'(pend_cnt), 32'd0);
      check("rst_mid_state", 32'(fsm_state), 32'd0);
      check("rst_mid_imm", dec_imm, 32'd0);
      rst = 1'b1;
      IR = IR_ADDI; W_IR_valid = 1'b1; dec_ready = 1'b1;
      tick();
      check("post_rst_valid", 32'(dec_valid), 32'd1);
      check("post_rst_rd", 32'(dec_rd), 32'd3);
      check("post_rst_imm", dec_imm, 32'd5);

      // Scoreboard full: fourth flag-setter is held until a slot frees
      IR = ir_c;
      tick(); tick(); tick(); tick();
      W_IR_valid = 1'b0;
      check("full_valid", 32'(dec_valid), 32'd0);
      check("full_state", 32'(fsm_state), 32'd2);
      check("full_pend", 32'(pend_cnt), 32'd3);
      check("full_ir_ready", 32'(ir_ready), 32'd0);
      flags_wr = 1'b1;
      tick(); flags_wr = 1'b0;
      check("full_free_valid", 32'(dec_valid), 32'd1);
      check("full_free_pend", 32'(pend_cnt), 32'd2);
      tick();
      check("full_handoff_pend", 32'(pend_cnt), 32'd3);
      check("full_handoff_state", 32'(fsm_state), 32'd0);
      flags_wr = 1'b1;
      tick(); tick(); tick();
      check("drain_pend", 32'(pend_cnt), 32'd0);
      tick();
      check("drain_ignore_at0", 32'(pend_cnt), 32'd0);
      flags_wr = 1'b0;

      // Condition table through branches
      for (int i = 0; i < 10; i++) begin
         IR = {cvec[i].cond, 2'b11, 26'h0000010};
         NZCV = cvec[i].flags; W_IR_valid = 1'b1;
         tick(); W_IR_valid = 1'b0;
         check($sformatf("cond_%0h_exec", cvec[i].cond), 32'(dec_exec), 32'(cvec[i].exp));
         check($sformatf("cond_%0h_imm", cvec[i].cond), dec_imm, 32'h00000040);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_instruction.md
# decode_instruction

Instruction decode stage directly downstream of the fetch stage. Accepts the 32-bit IR word and its valid flag, splits it into register indices, opcode and immediate, and resolves the condition field against NZCV. A flag-setting scoreboard ensures conditional instructions see up-to-date flags. Presents one registered decoded instruction at a time to the execute stage over a valid/ready handshake.

## Interface
- FLAG_DEPTH, 3: max flag-setting instructions handed off but not yet flag-written (counter is 2 bits).
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- IR  in  32  instruction word from fetch; stable while W_IR_valid high.
- W_IR_valid  in  1  IR holds a valid instruction; level, held until accepted.
- ir_ready  out  1  decode accepts IR this cycle (combinational).
- NZCV  in  4  current flags {N,Z,C,V}.
- flags_wr  in  1  one-cycle pulse: execute has written NZCV for the oldest in-flight S=1 instruction.
- dec_valid  out  1  decoded fields valid.
- dec_ready  in  1  execute accepts this cycle.
- dec_cls  out  2  class: 00 reg ALU, 01 imm ALU, 10 load/store, 11 branch.
- dec_op  out  4  IR[25:22] (classes 00–10), 0 for branch.
- dec_s  out  1  IR[21] (classes 00/01), else 0.
- dec_rd, dec_rs1, dec_rs2  out  5 each  IR[20:16], IR[15:11], IR[10:6]; 0 where the class has no such field.
- dec_imm  out  32  see Operation.
- dec_exec  out  1  condition passed; 0 means annulled bubble, execute ignores it.

## Operation
- Fields: cond=IR[31:28]; cls=IR[27:26].
- dec_imm:
  - cls 00: 0.
  - cls 01: zero-extended IR[10:0].
  - cls 10: sign-extended IR[10:0].
  - cls 11: sign-extended IR[25:0] shifted left 2.
- Conditions (ARM order):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Scoreboard pend_cnt:
  - +1 on handoff (dec_valid&dec_ready) with dec_s=1 and dec_exec=1.
  - −1 on flags_wr.
  - Both in the same cycle: unchanged.
  - flags_wr at 0: ignored.
- FSM states EMPTY, WAIT_FLAGS, OUT.
  - ir_ready = rst & (state==EMPTY | (state==OUT & dec_valid & dec_ready)).
  - Capture (W_IR_valid & ir_ready):
    - cond∈{E,F}, or effective pend_cnt==0: go to OUT; dec_exec evaluated from NZCV this cycle.
    - Otherwise: go to WAIT_FLAGS.
  - Effective pend_cnt is the count after this cycle's flags_wr. A flags_wr coinciding with capture counts.
  - WAIT_FLAGS: stay until pend_cnt==0. In the first cycle with pend_cnt==0, sample NZCV and go to OUT.
  - OUT:
    - dec_valid=1, except dec_valid=0 while dec_s=1 & dec_exec=1 & pend_cnt==FLAG_DEPTH.
    - On handoff with no new capture: go to EMPTY.
    - On handoff with a new capture: follow the capture rules.
- Decoded fields and dec_exec are frozen while in OUT. NZCV changes after evaluation are not seen.

## Timing
- Reset (rst low at an edge):
  - state EMPTY, pend_cnt 0.
  - All dec_* outputs 0.
  - ir_ready 0 while rst low.
- Reset mid-operation discards the held instruction and the scoreboard.
- Latency: IR captured at edge N → dec_valid high after edge N, with no wait.
- Throughput: one instruction per cycle while dec_ready stays high.
- dec_valid must not drop until handoff, except for the FLAG_DEPTH hold.
- Outputs are registered; only ir_ready is combinational.

## Structure
- Package cson_isa_pkg holds:
  - class codes and condition codes;
  - field bit positions;
  - the FSM state enum;
  - FLAG_DEPTH default.
- Sub-module cond_eval: combinational; inputs cond[3:0] and NZCV; output pass.

## Test plan
- ALU-immediate capture: IR=0xE4030805, W_IR_valid=1, dec_ready=1 → one cycle later:
  - dec_valid=1, cls=01, rd=3, rs1=1, imm=5, dec_exec=1;
  - next cycle EMPTY.
- Branch, condition passes: IR=0x0FFFFFFE (BEQ −2) with NZCV=0100 → cls=11, imm=0xFFFFFFF8, dec_exec=1.
- Branch, condition fails: same IR with NZCV=0000 → dec_exec=0, still handed off.
- Scoreboard wait: hand off S=1 ALU instruction, then capture BEQ →
  - WAIT_FLAGS, dec_valid=0;
  - flags_wr pulse with NZCV=0100 → dec_valid one cycle later, dec_exec=1.
- Back-pressure: dec_ready=0 for 3 cycles with W_IR_valid held →
  - ir_ready=0 and fields frozen;
  - dec_ready=1 → handoff and new capture in the same cycle.
- Reset in OUT: rst=0 for one edge → dec_valid=0, pend_cnt=0, next IR decoded normally.
